// File: rtl/md_pkg.sv
// Shared types and decode helpers for the RV32M multiply/divide unit.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package md_pkg;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic is_div(input md_op_e f);
        return f[2];
    endfunction

    function automatic logic is_rem(input md_op_e f);
        return f[2] & f[1];
    endfunction

    function automatic logic is_signed_a(input md_op_e f);
        return (f == OP_MUL) || (f == OP_MULH) || (f == OP_MULHSU) ||
               (f == OP_DIV) || (f == OP_REM);
    endfunction

    function automatic logic is_signed_b(input md_op_e f);
        return (f == OP_MUL) || (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate: absolute value of operands, sign fix of results.
// Latency: combinational.
// Backpressure: none.
// Ports: val_i value in, neg_i negate when 1, val_o result.
module md_sign_fix #(
    parameter int dataWidth = 32
) (
    input  logic [dataWidth-1:0] val_i,
    input  logic                 neg_i,
    output logic [dataWidth-1:0] val_o
);

    assign val_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide, one bit per cycle (shift-add mul, restoring div).
// Latency: result_valid rises dataWidth+1 edges after the accept edge; div-by-zero/overflow on the accept edge.
// Backpressure: start_ready only in IDLE; result and rdOut held in DONE until result_ready.
// Ports: Clk, reset (sync, active-low), kill (flush); start_valid/start_ready/op/opA/opB/rdIn request;
//        result_valid/result_ready/result/rdOut response; busy = not IDLE.
module md_unit
    import md_pkg::*;
#(
    parameter int dataWidth    = 32,
    parameter int AddressWidth = $clog2(dataWidth)
) (
    input  logic                    Clk,
    input  logic                    reset,
    input  logic                    kill,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [2:0]              op,
    input  logic [dataWidth-1:0]    opA,
    input  logic [dataWidth-1:0]    opB,
    input  logic [AddressWidth-1:0] rdIn,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [dataWidth-1:0]    result,
    output logic [AddressWidth-1:0] rdOut,
    output logic                    busy
);

    localparam int W  = dataWidth;
    localparam int CW = $clog2(dataWidth) + 1;

    md_state_e             state_q;
    md_op_e                op_q;
    logic [AddressWidth-1:0] rd_q;
    logic [2*W-1:0]        acc_q, acc_d;
    logic [W-1:0]          dvs_q;      // multiplicand (mul) or divisor (div) magnitude
    logic                  a_neg_q, b_neg_q;
    logic [CW-1:0]         cnt_q;
    logic [W-1:0]          res_q;
    logic                  vld_q;

    md_op_e                op_e;
    logic                  a_neg, b_neg;
    logic [W-1:0]          a_mag, b_mag;
    logic                  fast;
    logic [W-1:0]          fast_res;

    assign op_e  = md_op_e'(op);
    assign a_neg = is_signed_a(op_e) & opA[W-1];
    assign b_neg = is_signed_b(op_e) & opB[W-1];

    md_sign_fix #(.dataWidth(W)) u_abs_a (.val_i(opA), .neg_i(a_neg), .val_o(a_mag));
    md_sign_fix #(.dataWidth(W)) u_abs_b (.val_i(opB), .neg_i(b_neg), .val_o(b_mag));

    // Divide special cases resolved without iterating.
    always_comb begin
        logic div_zero, ovf;
        div_zero = (opB == '0);
        ovf      = (op_e == OP_DIV || op_e == OP_REM) &&
                   (opA == {1'b1, {(W-1){1'b0}}}) && (opB == '1);
        fast     = is_div(op_e) && (div_zero || ovf);
        fast_res = '0;
        if (div_zero)
            fast_res = is_rem(op_e) ? opA : '1;
        else if (op_e == OP_DIV)
            fast_res = opA;
    end

    // One iteration. Mul: add multiplicand into the high half when LSB set, shift right.
    // Div: shift left, trial subtract; the bit shifted out of the high half means the
    // remainder already exceeds any W-bit divisor.
    always_comb begin
        logic [W:0]   sum;
        logic [W:0]   rem_sh;
        logic         no_borrow;
        logic [W-1:0] sub;
        sum       = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
        rem_sh    = acc_q[2*W-1:W-1];
        no_borrow = rem_sh[W] | (rem_sh[W-1:0] >= dvs_q);
        sub       = rem_sh[W-1:0] - dvs_q;
        if (is_div(op_q))
            acc_d = {(no_borrow ? sub : rem_sh[W-1:0]), acc_q[W-2:0], no_borrow};
        else
            acc_d = {sum, acc_q[W-1:1]};
    end

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, fix_res;

    md_sign_fix #(.dataWidth(2*W)) u_fix_p (.val_i(acc_q), .neg_i(a_neg_q ^ b_neg_q), .val_o(prod_fix));
    md_sign_fix #(.dataWidth(W)) u_fix_q (.val_i(acc_q[W-1:0]), .neg_i(a_neg_q ^ b_neg_q), .val_o(quo_fix));
    md_sign_fix #(.dataWidth(W)) u_fix_r (.val_i(acc_q[2*W-1:W]), .neg_i(a_neg_q), .val_o(rem_fix));

    always_comb begin
        fix_res = rem_fix;
        case (op_q)
            OP_MUL:                        fix_res = prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_fix[2*W-1:W];
            OP_DIV, OP_DIVU:               fix_res = quo_fix;
            default:                       fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MUL;
            rd_q    <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            vld_q   <= 1'b0;
        end else if (kill) begin
            state_q <= ST_IDLE;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_valid) begin
                        op_q    <= op_e;
                        rd_q    <= rdIn;
                        a_neg_q <= a_neg;
                        b_neg_q <= b_neg;
                        cnt_q   <= CW'(W);
                        if (fast) begin
                            res_q   <= fast_res;
                            vld_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            // mul: multiplier in low half; div: dividend in low half
                            acc_q   <= {{W{1'b0}}, (is_div(op_e) ? a_mag : b_mag)};
                            dvs_q   <= is_div(op_e) ? b_mag : a_mag;
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1))
                        state_q <= ST_FIX;
                end
                ST_FIX: begin
                    res_q   <= fix_res;
                    vld_q   <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (result_ready) begin
                        vld_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign start_ready  = (state_q == ST_IDLE) && reset;
    assign busy         = (state_q != ST_IDLE);
    assign result_valid = vld_q;
    assign result       = res_q;
    assign rdOut        = rd_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed RV32M cases plus random ops against a 64-bit arithmetic model.
// Latency: n/a.
// Backpressure: exercises held results, kill and reset mid-operation.
module tb_md_unit;

    localparam int W  = 32;
    localparam int AW = $clog2(W);

    logic          Clk = 1'b0;
    logic          reset = 1'b0;
    logic          kill = 1'b0;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  opA = '0;
    logic [W-1:0]  opB = '0;
    logic [AW-1:0] rdIn = '0;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic [W-1:0]  result;
    logic [AW-1:0] rdOut;
    logic          busy;

    int n_checks = 0;
    int n_err    = 0;

    md_unit #(.dataWidth(W)) dut (
        .Clk(Clk), .reset(reset), .kill(kill),
        .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .opA(opA), .opB(opB), .rdIn(rdIn),
        .result_valid(result_valid), .result_ready(result_ready),
        .result(result), .rdOut(rdOut), .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference from the instruction definitions using 64-bit integer arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = 0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Issue one op, measure accept-to-valid latency (accept edge counts as 1), check, handshake.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [AW-1:0] rd, input string tag);
        int          lat;
        logic [31:0] exp;
        logic        fast;
        exp  = ref_md(f, a, b);
        fast = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        @(negedge Clk);
        check({tag, " start_ready"}, 64'(start_ready), 64'd1);
        start_valid = 1'b1; op = f; opA = a; opB = b; rdIn = rd;
        @(posedge Clk); #1;
        start_valid = 1'b0; opA = $urandom; opB = $urandom; rdIn = AW'($urandom);
        lat = 1;
        while (!result_valid && lat < 200) begin
            @(posedge Clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), fast ? 64'd1 : 64'(W + 2));
        check({tag, " result"}, 64'(result), 64'(exp));
        check({tag, " rdOut"}, 64'(rdOut), 64'(rd));
        @(negedge Clk); result_ready = 1'b1;
        @(posedge Clk); #1; result_ready = 1'b0;
        check({tag, " valid drop"}, 64'(result_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] a, b, exp;
        logic [2:0]  f;
        int          seen;

        // reset state
        repeat (3) @(posedge Clk);
        #1;
        check("rst valid", 64'(result_valid), 64'd0);
        check("rst result", 64'(result), 64'd0);
        check("rst rdOut", 64'(rdOut), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst start_ready", 64'(start_ready), 64'd0);
        @(negedge Clk); reset = 1'b1;

        // directed cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, "MUL 7*-3");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, "MULH");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "MULHU");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, "MULHSU");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, "DIV -7/2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, "REM -7/2");
        run_op(3'd5, 32'd100, 32'd7, 5'd6, "DIVU 100/7");
        run_op(3'd7, 32'd100, 32'd7, 5'd7, "REMU 100/7");
        run_op(3'd5, 32'd5, 32'd0, 5'd8, "DIVU /0");
        run_op(3'd7, 32'd5, 32'd0, 5'd10, "REMU /0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, "DIV ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, "REM ovf");
        run_op(3'd4, 32'd9, 32'd0, 5'd13, "DIV /0");

        // held result with start_valid pulses while DONE
        @(negedge Clk);
        start_valid = 1'b1; op = 3'd3; opA = 32'h1234_5678; opB = 32'h9ABC_DEF0; rdIn = 5'd21;
        @(posedge Clk); #1; start_valid = 1'b0;
        exp = ref_md(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        seen = 0;
        while (!result_valid && seen < 100) begin @(posedge Clk); #1; seen++; end
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            start_valid = i[0]; op = 3'd0; opA = $urandom; opB = $urandom; rdIn = 5'd3;
            @(posedge Clk); #1;
            check("hold valid", 64'(result_valid), 64'd1);
            check("hold result", 64'(result), 64'(exp));
            check("hold rdOut", 64'(rdOut), 64'd21);
            check("hold start_ready", 64'(start_ready), 64'd0);
        end
        @(negedge Clk); start_valid = 1'b0; result_ready = 1'b1;
        @(posedge Clk); #1; result_ready = 1'b0;
        check("hold release", 64'(busy), 64'd0);

        // kill at CALC cycle 10
        @(negedge Clk);
        start_valid = 1'b1; op = 3'd4; opA = 32'd1000; opB = 32'd3; rdIn = 5'd17;
        @(posedge Clk); #1; start_valid = 1'b0;
        repeat (9) @(posedge Clk);
        @(negedge Clk);
        check("kill pre busy", 64'(busy), 64'd1);
        kill = 1'b1;
        @(posedge Clk); #1; kill = 1'b0;
        check("kill valid", 64'(result_valid), 64'd0);
        check("kill start_ready", 64'(start_ready), 64'd1);
        check("kill busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (40) begin @(posedge Clk); #1; if (result_valid) seen++; end
        check("kill no result", 64'(seen), 64'd0);

        // kill together with start_valid in IDLE: not accepted
        @(negedge Clk); kill = 1'b1; start_valid = 1'b1; op = 3'd0;
        @(posedge Clk); #1; kill = 1'b0; start_valid = 1'b0;
        check("kill+start busy", 64'(busy), 64'd0);

        // reset mid-CALC (previous result nonzero)
        run_op(3'd0, 32'd3, 32'd5, 5'd30, "MUL pre-rst");
        @(negedge Clk);
        start_valid = 1'b1; op = 3'd1; opA = 32'hDEAD_BEEF; opB = 32'h1357_9BDF; rdIn = 5'd19;
        @(posedge Clk); #1; start_valid = 1'b0;
        repeat (5) @(posedge Clk);
        @(negedge Clk); reset = 1'b0;
        @(posedge Clk); #1;
        check("mid-rst busy", 64'(busy), 64'd0);
        check("mid-rst valid", 64'(result_valid), 64'd0);
        check("mid-rst result", 64'(result), 64'd0);
        check("mid-rst rdOut", 64'(rdOut), 64'd0);
        check("mid-rst start_ready", 64'(start_ready), 64'd0);
        @(negedge Clk); reset = 1'b1; #1;
        check("post-rst start_ready", 64'(start_ready), 64'd1);

        // random ops, biased towards corner operands
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            run_op(f, a, b, AW'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
